mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous memory between the CPU instruction-fetch port
//  (IADDR/IEN) and data port (DADDR/DWR/DEN). Sits between CPU and the unified memory.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between the CPU fetch and data ports.
// Data wins by default; a streak counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          IEN,
    input  logic [AW-1:0] IADDR,
    output logic [DW-1:0] INSTR_IN,
    output logic          I_ACK,
    input  logic          DEN,
    input  logic          DWR,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DATA_OUT,
    output logic [DW-1:0] DATA_IN,
    output logic          D_ACK,
    output logic          MEN,
    output logic          MWR,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic [DW-1:0] MRDATA
);

    typedef enum logic [2:0] {StIdle, StGntI, StGntD, StRespI, StRespD} state_e;

    localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] d_streak_q, d_streak_d;
    logic             men_q, men_d;
    logic             mwr_q, mwr_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic [DW-1:0]    mwdata_q, mwdata_d;
    logic [DW-1:0]    instr_q, instr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             take_d, take_i;

    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        men_d      = 1'b0;
        mwr_d      = 1'b0;
        maddr_d    = '0;
        mwdata_d   = '0;
        instr_d    = instr_q;
        data_d     = data_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        take_d     = 1'b0;
        take_i     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Fetch overrides data only once the streak has hit the limit.
                take_d = DEN && !(IEN && (d_streak_q == StarveLimit));
                take_i = IEN && !take_d;
                if (take_d) begin
                    state_d  = StGntD;
                    men_d    = 1'b1;
                    mwr_d    = DWR;
                    maddr_d  = DADDR;
                    mwdata_d = DWR ? DATA_OUT : '0;
                    if (!IEN) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != StarveLimit) begin
                        d_streak_d = d_streak_q + CNT_W'(1);
                    end
                end else if (take_i) begin
                    state_d    = StGntI;
                    men_d      = 1'b1;
                    maddr_d    = IADDR;
                    d_streak_d = '0;
                end
            end
            StGntI: state_d = StRespI;
            StGntD: begin
                // Writes complete with the grant itself; no read data to wait for.
                if (mwr_q) begin
                    d_ack_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StRespD;
                end
            end
            StRespI: begin
                instr_d = MRDATA;
                i_ack_d = 1'b1;
                state_d = StIdle;
            end
            StRespD: begin
                data_d  = MRDATA;
                d_ack_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            d_streak_q <= '0;
            men_q      <= 1'b0;
            mwr_q      <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            instr_q    <= '0;
            data_q     <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            men_q      <= men_d;
            mwr_q      <= mwr_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    assign MEN      = men_q;
    assign MWR      = mwr_q;
    assign MADDR    = maddr_q;
    assign MWDATA   = mwdata_q;
    assign INSTR_IN = instr_q;
    assign DATA_IN  = data_q;
    assign I_ACK    = i_ack_q;
    assign D_ACK    = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory model plus grant/response scoreboards
// that are filled when requests are driven and drained as the arbiter grants and acknowledges.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic        IEN, DEN, DWR;
    logic [31:0] IADDR, DADDR, DATA_OUT;
    logic [31:0] INSTR_IN, DATA_IN, MADDR, MWDATA, MRDATA;
    logic        I_ACK, D_ACK, MEN, MWR;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .IEN      (IEN),
        .IADDR    (IADDR),
        .INSTR_IN (INSTR_IN),
        .I_ACK    (I_ACK),
        .DEN      (DEN),
        .DWR      (DWR),
        .DADDR    (DADDR),
        .DATA_OUT (DATA_OUT),
        .DATA_IN  (DATA_IN),
        .D_ACK    (D_ACK),
        .MEN      (MEN),
        .MWR      (MWR),
        .MADDR    (MADDR),
        .MWDATA   (MWDATA),
        .MRDATA   (MRDATA)
    );

    // Synchronous single-port memory with a backdoor preload path.
    logic [31:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'd0;
    logic [31:0] bd_data = 32'd0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (MEN) begin
            if (MWR) mem[MADDR[7:0]] <= MWDATA;
            else     MRDATA <= mem[MADDR[7:0]];
        end
    end

    typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] wdata;} grant_t;
    typedef struct packed {logic rd; logic [31:0] val;} resp_t;

    grant_t      gq[$];
    resp_t       iq[$];
    resp_t       dq[$];
    logic [31:0] exp_mem [0:255];
    logic [31:0] last_instr = 32'd0;
    logic [31:0] last_data  = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          cyc, cyc_d, cyc_i, n_iack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; exp_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Advance one cycle and reconcile every DUT output against the scoreboards.
    task automatic tick();
        grant_t g;
        resp_t  r;
        @(posedge clk); #1;
        if (gq.size() == 0) chk("men_unexpected", {63'd0, MEN}, 64'd0);
        else if (MEN) begin
            g = gq.pop_front();
            chk("maddr", {32'd0, MADDR}, {32'd0, g.addr});
            chk("mwr", {63'd0, MWR}, {63'd0, g.wr});
            chk("mwdata", {32'd0, MWDATA}, {32'd0, g.wdata});
        end
        if (!MEN) begin
            chk("maddr_idle", {32'd0, MADDR}, 64'd0);
            chk("mwdata_idle", {32'd0, MWDATA}, 64'd0);
        end
        if (iq.size() == 0) chk("i_ack_unexpected", {63'd0, I_ACK}, 64'd0);
        else if (I_ACK) begin
            r = iq.pop_front();
            chk("instr_in", {32'd0, INSTR_IN}, {32'd0, r.val});
            last_instr = r.val;
        end
        if (!I_ACK) chk("instr_hold", {32'd0, INSTR_IN}, {32'd0, last_instr});
        if (dq.size() == 0) chk("d_ack_unexpected", {63'd0, D_ACK}, 64'd0);
        else if (D_ACK) begin
            r = dq.pop_front();
            if (r.rd) begin
                chk("data_in", {32'd0, DATA_IN}, {32'd0, r.val});
                last_data = r.val;
            end else begin
                chk("data_in_write_hold", {32'd0, DATA_IN}, {32'd0, last_data});
            end
        end
        if (!D_ACK) chk("data_hold", {32'd0, DATA_IN}, {32'd0, last_data});
    endtask

    // Tick until the selected ack appears; n = cycles taken, 0 on timeout.
    task automatic run_to_ack(input bit want_i, input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if ((want_i && I_ACK) || (!want_i && D_ACK)) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        RST = 1'b0; IEN = 1'b0; DEN = 1'b0; DWR = 1'b0;
        IADDR = '0; DADDR = '0; DATA_OUT = '0;
        preload(8'h03, 32'h4000_0064);
        preload(8'h05, 32'h5555_0005);
        preload(8'h07, 32'h7777_0007);
        preload(8'h09, 32'h9999_0009);
        preload(8'h10, 32'h1010_1010);
        preload(8'h20, 32'h2020_2020);

        // Reset state
        tick();
        chk("rst_men", {63'd0, MEN}, 64'd0);
        chk("rst_mwr", {63'd0, MWR}, 64'd0);
        chk("rst_i_ack", {63'd0, I_ACK}, 64'd0);
        chk("rst_d_ack", {63'd0, D_ACK}, 64'd0);
        chk("rst_instr", {32'd0, INSTR_IN}, 64'd0);
        chk("rst_data", {32'd0, DATA_IN}, 64'd0);
        RST = 1'b1;
        tick();

        // 1. Single fetch
        IEN = 1'b1; IADDR = 32'd3;
        gq.push_back('{addr: 32'd3, wr: 1'b0, wdata: 32'd0});
        iq.push_back('{rd: 1'b1, val: exp_mem[3]});
        run_to_ack(1'b1, 10, cyc);
        IEN = 1'b0;
        chk("fetch_latency", 64'(cyc), 64'd3);
        tick();

        // 2. Write then read back
        DEN = 1'b1; DWR = 1'b1; DADDR = 32'd0; DATA_OUT = 32'h46D;
        exp_mem[0] = 32'h46D;
        gq.push_back('{addr: 32'd0, wr: 1'b1, wdata: 32'h46D});
        dq.push_back('{rd: 1'b0, val: 32'd0});
        run_to_ack(1'b0, 10, cyc);
        chk("write_latency", 64'(cyc), 64'd2);
        DWR = 1'b0; DATA_OUT = 32'hDEAD_BEEF;
        gq.push_back('{addr: 32'd0, wr: 1'b0, wdata: 32'd0});
        dq.push_back('{rd: 1'b1, val: exp_mem[0]});
        run_to_ack(1'b0, 10, cyc);
        DEN = 1'b0;
        chk("read_latency", 64'(cyc), 64'd3);
        tick();

        // 3. Simultaneous requests: data first, then fetch
        IEN = 1'b1; IADDR = 32'd5; DEN = 1'b1; DWR = 1'b0; DADDR = 32'd7;
        gq.push_back('{addr: 32'd7, wr: 1'b0, wdata: 32'd0});
        gq.push_back('{addr: 32'd5, wr: 1'b0, wdata: 32'd0});
        dq.push_back('{rd: 1'b1, val: exp_mem[7]});
        iq.push_back('{rd: 1'b1, val: exp_mem[5]});
        cyc_d = 0; cyc_i = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (D_ACK) begin cyc_d = k; DEN = 1'b0; end
            if (I_ACK) begin cyc_i = k; IEN = 1'b0; break; end
        end
        IEN = 1'b0; DEN = 1'b0;
        chk("simul_d_ack", 64'(cyc_d), 64'd3);
        chk("simul_i_ack", 64'(cyc_i), 64'd6);
        tick();

        // 4. Starvation: both held, reads, limit 4
        IEN = 1'b1; IADDR = 32'h10; DEN = 1'b1; DWR = 1'b0; DADDR = 32'h20;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                gq.push_back('{addr: 32'h20, wr: 1'b0, wdata: 32'd0});
                dq.push_back('{rd: 1'b1, val: exp_mem[8'h20]});
            end
            gq.push_back('{addr: 32'h10, wr: 1'b0, wdata: 32'd0});
            iq.push_back('{rd: 1'b1, val: exp_mem[8'h10]});
        end
        cyc_i = 0; cyc_d = 0; n_iack = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (I_ACK) begin
                n_iack++;
                if (n_iack == 1) cyc_i = k;
                else begin cyc_d = k; break; end
            end
        end
        IEN = 1'b0; DEN = 1'b0;
        chk("starve_first_i_ack", 64'(cyc_i), 64'd15);
        chk("starve_second_i_ack", 64'(cyc_d), 64'd30);
        tick();

        // 5. Reset during RESP_D, then re-arbitrate the held request
        DEN = 1'b1; DWR = 1'b0; DADDR = 32'd9;
        gq.push_back('{addr: 32'd9, wr: 1'b0, wdata: 32'd0});
        dq.push_back('{rd: 1'b1, val: exp_mem[9]});
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_mid_men", {63'd0, MEN}, 64'd0);
        chk("rst_mid_d_ack", {63'd0, D_ACK}, 64'd0);
        chk("rst_mid_data", {32'd0, DATA_IN}, 64'd0);
        chk("rst_mid_instr", {32'd0, INSTR_IN}, 64'd0);
        void'(dq.pop_front());
        last_data = 32'd0; last_instr = 32'd0;
        tick();
        tick();
        RST = 1'b1;
        gq.push_back('{addr: 32'd9, wr: 1'b0, wdata: 32'd0});
        dq.push_back('{rd: 1'b1, val: exp_mem[9]});
        run_to_ack(1'b0, 10, cyc);
        DEN = 1'b0;
        chk("post_rst_latency", 64'(cyc), 64'd3);

        // 6. Idle: nothing granted, read data held
        for (int k = 0; k < 20; k++) tick();

        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("iq_drained", 64'(iq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
